// File: rtl/window_scan_ctrl.sv
// Sequencer for the 3x3-window image memory: streams a binary image in, or scans every valid window in raster order.
// Latency: first read issues on the start edge; window tags reach the outputs RD_LAT cycles after their read; done follows win_last by one cycle.
// Backpressure: i_stall freezes scan issue, but reads already in flight still arrive; the load stream accepts at most one pixel per cycle.
//
// Ports: clk/rst (synchronous, active-high); i_start/i_mode request an operation (0 = scan, 1 = load);
// i_stall holds scan issue; i_pix_valid/i_pix_data/o_pix_ready form the load stream;
// o_mem_* drive the window memory; o_win_* are tags aligned with the memory window outputs;
// o_busy is high while an operation runs; o_done pulses once when it completes.
module window_scan_ctrl #(
    parameter int IMG_COLS = 340,
    parameter int IMG_ROWS = 440,
    parameter int ADDR_W   = 18,
    parameter int RD_LAT   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_mode,
    input  logic              i_stall,
    input  logic              i_pix_valid,
    input  logic              i_pix_data,
    output logic              o_pix_ready,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_ena,
    output logic              o_mem_rd,
    output logic              o_mem_wr,
    output logic              o_mem_din,
    output logic              o_win_valid,
    output logic [8:0]        o_win_row,
    output logic [8:0]        o_win_col,
    output logic              o_win_last,
    output logic              o_busy,
    output logic              o_done
);

    localparam logic [8:0]        LAST_COL   = 9'(IMG_COLS - 3);
    localparam logic [8:0]        LAST_ROW   = 9'(IMG_ROWS - 3);
    localparam logic [ADDR_W-1:0] LAST_WADDR = ADDR_W'(IMG_COLS * IMG_ROWS - 1);
    localparam int                DCW        = $clog2(RD_LAT + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SCAN, S_DRAIN, S_FIN} state_t;

    typedef struct packed {
        logic       vld;
        logic [8:0] row;
        logic [8:0] col;
        logic       last;
    } tag_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;    // scan: top-left of next window; load: write count
    logic [8:0]        r_row;
    logic [8:0]        r_col;
    logic [DCW-1:0]    r_dcnt;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_ena;
    logic              r_mem_rd;
    logic              r_mem_wr;
    logic              r_mem_din;
    logic              r_pix_ready;
    logic              r_busy;
    logic              r_done;
    // Entry 0 is aligned with the registered read; entry RD_LAT with the memory outputs.
    tag_t              r_pipe [0:RD_LAT];

    logic w_row_end;
    logic w_last_win;
    logic w_scan_issue;

    assign w_row_end  = (r_col == LAST_COL);
    assign w_last_win = w_row_end && (r_row == LAST_ROW);
    // The start edge itself issues window (0,0), so the first read lands the cycle after start.
    assign w_scan_issue = !i_stall &&
                          ((r_state == S_SCAN) || ((r_state == S_IDLE) && i_start && !i_mode));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_dcnt      <= '0;
            r_mem_addr  <= '0;
            r_mem_ena   <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_din   <= 1'b0;
            r_pix_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            for (int i = 0; i <= RD_LAT; i++) r_pipe[i] <= '0;
        end else begin
            r_mem_ena <= 1'b0;
            r_mem_rd  <= 1'b0;
            r_mem_wr  <= 1'b0;
            r_done    <= 1'b0;
            r_pipe[0] <= '0;
            for (int i = 1; i <= RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];

            case (r_state)
                S_IDLE: begin
                    r_addr <= '0;
                    r_row  <= '0;
                    r_col  <= '0;
                    if (i_start) begin
                        r_busy <= 1'b1;
                        if (i_mode) begin
                            r_state     <= S_LOAD;
                            r_pix_ready <= 1'b1;
                        end else begin
                            r_state <= S_SCAN;
                        end
                    end
                end
                S_LOAD: begin
                    if (i_pix_valid) begin
                        r_mem_addr <= r_addr;
                        r_mem_din  <= i_pix_data;
                        r_mem_wr   <= 1'b1;
                        r_mem_ena  <= 1'b1;
                        r_addr     <= r_addr + ADDR_W'(1);
                        if (r_addr == LAST_WADDR) begin
                            r_state     <= S_FIN;
                            r_pix_ready <= 1'b0;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                        end
                    end
                end
                S_SCAN: begin
                end
                S_DRAIN: begin
                    // Wait for the final tag to reach the pipe tail before signalling done.
                    if (r_dcnt == DCW'(RD_LAT)) begin
                        r_state <= S_FIN;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_dcnt <= r_dcnt + DCW'(1);
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                    r_addr  <= '0;
                    r_row   <= '0;
                    r_col   <= '0;
                end
                default: r_state <= S_IDLE;
            endcase

            // Placed after the case so its counter/state updates take priority.
            if (w_scan_issue) begin
                r_mem_addr <= r_addr;
                r_mem_rd   <= 1'b1;
                r_mem_ena  <= 1'b1;
                r_pipe[0]  <= '{vld: 1'b1, row: r_row, col: r_col, last: w_last_win};
                if (w_row_end) begin
                    // Skip the two columns whose window would run off the row end.
                    r_col  <= '0;
                    r_row  <= r_row + 9'd1;
                    r_addr <= r_addr + ADDR_W'(3);
                end else begin
                    r_col  <= r_col + 9'd1;
                    r_addr <= r_addr + ADDR_W'(1);
                end
                if (w_last_win) begin
                    r_state <= S_DRAIN;
                    r_dcnt  <= '0;
                end
            end
        end
    end

    assign o_pix_ready = r_pix_ready;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_ena   = r_mem_ena;
    assign o_mem_rd    = r_mem_rd;
    assign o_mem_wr    = r_mem_wr;
    assign o_mem_din   = r_mem_din;
    assign o_win_valid = r_pipe[RD_LAT].vld;
    assign o_win_row   = r_pipe[RD_LAT].row;
    assign o_win_col   = r_pipe[RD_LAT].col;
    assign o_win_last  = r_pipe[RD_LAT].last;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Directed bench for window_scan_ctrl: a 5x4 instance for scan/stall/load sequences and a default-size instance for row wrap and reset.
// Latency: outputs sampled 1 time unit after each rising edge; inputs changed then are seen at the next edge.
// Backpressure: stall applied for four consecutive edges mid-row in one scan.
module tb_window_scan_ctrl;

    logic clk;
    logic rst;
    logic start, mode, stall, pix_valid, pix_data;
    logic        pix_ready, mem_ena, mem_rd, mem_wr, mem_din;
    logic [17:0] mem_addr;
    logic        win_valid, win_last, busy, done;
    logic [8:0]  win_row, win_col;

    logic        d_start;
    logic        d_pix_ready, d_mem_ena, d_mem_rd, d_mem_wr, d_mem_din;
    logic [17:0] d_mem_addr;
    logic        d_win_valid, d_win_last, d_busy, d_done;
    logic [8:0]  d_win_row, d_win_col;

    int total = 0;
    int bad   = 0;

    int e_rd [16], e_addr [16], e_wv [16], e_row [16], e_col [16];
    int e_last [16], e_done [16], e_busy [16], st_m [16], md_m [16], sl_m [16];

    window_scan_ctrl #(.IMG_COLS(5), .IMG_ROWS(4), .ADDR_W(18), .RD_LAT(3)) dut (
        .clk(clk), .rst(rst), .i_start(start), .i_mode(mode), .i_stall(stall),
        .i_pix_valid(pix_valid), .i_pix_data(pix_data), .o_pix_ready(pix_ready),
        .o_mem_addr(mem_addr), .o_mem_ena(mem_ena), .o_mem_rd(mem_rd), .o_mem_wr(mem_wr),
        .o_mem_din(mem_din), .o_win_valid(win_valid), .o_win_row(win_row), .o_win_col(win_col),
        .o_win_last(win_last), .o_busy(busy), .o_done(done)
    );

    window_scan_ctrl dut_d (
        .clk(clk), .rst(rst), .i_start(d_start), .i_mode(1'b0), .i_stall(1'b0),
        .i_pix_valid(1'b0), .i_pix_data(1'b0), .o_pix_ready(d_pix_ready),
        .o_mem_addr(d_mem_addr), .o_mem_ena(d_mem_ena), .o_mem_rd(d_mem_rd), .o_mem_wr(d_mem_wr),
        .o_mem_din(d_mem_din), .o_win_valid(d_win_valid), .o_win_row(d_win_row), .o_win_col(d_win_col),
        .o_win_last(d_win_last), .o_busy(d_busy), .o_done(d_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Starts a scan on the 5x4 instance and compares n cycles against the e_* tables.
    // st_m/md_m/sl_m give the start/mode/stall values applied after observing cycle k.
    task automatic run_scan(input string nm, input int n);
        start = 1'b1;
        mode  = 1'b0;
        tick();
        for (int k = 0; k < n; k++) begin
            if (k > 0) tick();
            start = (st_m[k] != 0);
            mode  = (md_m[k] != 0);
            stall = (sl_m[k] != 0);
            chk($sformatf("%s_rd_%0d", nm, k), 64'(mem_rd), 64'(e_rd[k]));
            chk($sformatf("%s_wr_%0d", nm, k), 64'(mem_wr), 64'd0);
            if (e_addr[k] >= 0) chk($sformatf("%s_addr_%0d", nm, k), 64'(mem_addr), 64'(e_addr[k]));
            chk($sformatf("%s_wv_%0d", nm, k), 64'(win_valid), 64'(e_wv[k]));
            if (e_wv[k] != 0) begin
                chk($sformatf("%s_row_%0d", nm, k), 64'(win_row), 64'(e_row[k]));
                chk($sformatf("%s_col_%0d", nm, k), 64'(win_col), 64'(e_col[k]));
            end
            chk($sformatf("%s_last_%0d", nm, k), 64'(win_last), 64'(e_last[k]));
            chk($sformatf("%s_done_%0d", nm, k), 64'(done), 64'(e_done[k]));
            chk($sformatf("%s_busy_%0d", nm, k), 64'(busy), 64'(e_busy[k]));
        end
        start = 1'b0;
        mode  = 1'b0;
        stall = 1'b0;
    endtask

    initial begin
        logic [19:0] pat;
        int          cnt;
        pat = 20'hB4E39;

        rst = 1'b1; start = 1'b0; mode = 1'b0; stall = 1'b0;
        pix_valid = 1'b0; pix_data = 1'b0; d_start = 1'b0;
        tick();
        tick();
        chk("reset_small_outs", 64'({pix_ready, mem_addr, mem_ena, mem_rd, mem_wr, mem_din,
                                     win_valid, win_row, win_col, win_last, busy, done}), 64'd0);
        chk("reset_dflt_outs", 64'({d_pix_ready, d_mem_addr, d_mem_ena, d_mem_rd, d_mem_wr, d_mem_din,
                                    d_win_valid, d_win_row, d_win_col, d_win_last, d_busy, d_done}), 64'd0);
        rst = 1'b0;
        tick();

        // Default image: first issue, row wrap at column 337, then reset with reads in flight.
        d_start = 1'b1;
        tick();
        d_start = 1'b0;
        chk("dflt_first_rd", 64'(d_mem_rd), 64'd1);
        chk("dflt_first_addr", 64'(d_mem_addr), 64'd0);
        chk("dflt_busy", 64'(d_busy), 64'd1);
        repeat (3) tick();
        chk("dflt_first_wv", 64'(d_win_valid), 64'd1);
        chk("dflt_first_tag", 64'({d_win_row, d_win_col}), 64'd0);
        repeat (334) tick();
        chk("dflt_addr_337", 64'(d_mem_addr), 64'd337);
        tick();
        chk("dflt_addr_wrap", 64'(d_mem_addr), 64'd340);
        chk("dflt_rd_wrap", 64'(d_mem_rd), 64'd1);
        repeat (2) tick();
        chk("dflt_tag_rowend", 64'({d_win_valid, d_win_row, d_win_col}), 64'({1'b1, 9'd0, 9'd337}));
        tick();
        chk("dflt_tag_row1", 64'({d_win_valid, d_win_row, d_win_col}), 64'({1'b1, 9'd1, 9'd0}));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_outs", 64'({d_pix_ready, d_mem_addr, d_mem_ena, d_mem_rd, d_mem_wr, d_mem_din,
                                d_win_valid, d_win_row, d_win_col, d_win_last, d_busy, d_done}), 64'd0);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (d_win_valid) cnt++;
        end
        chk("midrst_no_wv", 64'(cnt), 64'd0);
        chk("midrst_idle", 64'(d_busy), 64'd0);
        d_start = 1'b1;
        tick();
        d_start = 1'b0;
        chk("restart_addr", 64'({d_mem_rd, d_mem_addr}), 64'({1'b1, 18'd0}));
        repeat (3) tick();
        chk("restart_tag", 64'({d_win_valid, d_win_row, d_win_col}), 64'({1'b1, 9'd0, 9'd0}));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // 5x4 scan, no stall; stray starts (load and scan) while busy must be ignored.
        e_rd   = '{1,1,1,1,1,1,0,0,0,0,0,0,0,0,0,0};
        e_addr = '{0,1,2,5,6,7,-1,-1,-1,-1,-1,-1,-1,-1,-1,-1};
        e_wv   = '{0,0,0,1,1,1,1,1,1,0,0,0,0,0,0,0};
        e_row  = '{0,0,0,0,0,0,1,1,1,0,0,0,0,0,0,0};
        e_col  = '{0,0,0,0,1,2,0,1,2,0,0,0,0,0,0,0};
        e_last = '{0,0,0,0,0,0,0,0,1,0,0,0,0,0,0,0};
        e_done = '{0,0,0,0,0,0,0,0,0,1,0,0,0,0,0,0};
        e_busy = '{1,1,1,1,1,1,1,1,1,0,0,0,0,0,0,0};
        st_m   = '{0,1,0,0,1,0,1,0,0,0,0,0,0,0,0,0};
        md_m   = '{0,1,0,0,0,0,1,0,0,0,0,0,0,0,0,0};
        sl_m   = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
        run_scan("scan", 11);
        chk("scan_back_idle", 64'({busy, pix_ready, mem_ena}), 64'd0);

        // 5x4 scan with stall held for four edges between columns 1 and 2 of row 0.
        e_rd   = '{1,1,0,0,0,0,1,1,1,1,0,0,0,0,0,0};
        e_addr = '{0,1,-1,-1,-1,-1,2,5,6,7,-1,-1,-1,-1,-1,-1};
        e_wv   = '{0,0,0,1,1,0,0,0,0,1,1,1,1,0,0,0};
        e_row  = '{0,0,0,0,0,0,0,0,0,0,1,1,1,0,0,0};
        e_col  = '{0,0,0,0,1,0,0,0,0,2,0,1,2,0,0,0};
        e_last = '{0,0,0,0,0,0,0,0,0,0,0,0,1,0,0,0};
        e_done = '{0,0,0,0,0,0,0,0,0,0,0,0,0,1,0,0};
        e_busy = '{1,1,1,1,1,1,1,1,1,1,1,1,1,0,0,0};
        st_m   = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
        md_m   = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
        sl_m   = '{0,1,1,1,1,0,0,0,0,0,0,0,0,0,0,0};
        run_scan("stall", 15);

        // 5x4 load, pix_valid on every other cycle, 20 beats.
        start = 1'b1;
        mode  = 1'b1;
        tick();
        start = 1'b0;
        mode  = 1'b0;
        chk("load_ready", 64'(pix_ready), 64'd1);
        chk("load_busy", 64'(busy), 64'd1);
        chk("load_nowr", 64'({mem_wr, mem_rd, mem_ena}), 64'd0);
        for (int i = 0; i < 20; i++) begin
            pix_valid = 1'b1;
            pix_data  = pat[i];
            tick();
            pix_valid = 1'b0;
            pix_data  = ~pat[i];
            chk($sformatf("load_wr_%0d", i), 64'({mem_wr, mem_ena, mem_rd}), 64'({1'b1, 1'b1, 1'b0}));
            chk($sformatf("load_addr_%0d", i), 64'(mem_addr), 64'(i));
            chk($sformatf("load_din_%0d", i), 64'(mem_din), 64'(pat[i]));
            chk($sformatf("load_done_%0d", i), 64'(done), 64'(i == 19));
            chk($sformatf("load_rdy_%0d", i), 64'(pix_ready), 64'(i != 19));
            tick();
            chk($sformatf("load_gap_%0d", i), 64'({mem_wr, mem_ena, done}), 64'd0);
            chk($sformatf("load_gapbusy_%0d", i), 64'(busy), 64'(i != 19));
        end
        chk("load_no_wv", 64'(win_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
